// File: rtl/card_deck_dealer.sv
// 52-card deck with LFSR-driven in-place Fisher-Yates shuffle and a
// round-robin card server for the player (req[0]) and dealer (req[1]).
module card_deck_dealer #(
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1,
  parameter int          DECK_SIZE    = 52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shuffle_start,
  input  logic [15:0] seed,
  input  logic [1:0]  req,
  output logic [1:0]  grant,
  output logic        card_valid,
  output logic [3:0]  card_value,
  output logic [3:0]  card_rank,
  output logic [1:0]  card_suit,
  output logic        busy,
  output logic        deck_empty,
  output logic [5:0]  cards_left
);

  typedef enum logic [1:0] {READY, SHUFFLE, SERVE} state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [5:0]  FULL      = 6'(DECK_SIZE);
  localparam logic [5:0]  LAST_IDX  = 6'(DECK_SIZE - 1);

  state_t      state_q, state_d;
  logic [5:0]  deck_q [DECK_SIZE];
  logic [5:0]  deck_d [DECK_SIZE];
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  left_q, left_d;
  logic [5:0]  i_q, i_d;
  logic [5:0]  card_q, card_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        last_q, last_d;   // 1 = dealer received the most recent card
  logic        win_q, win_d;

  logic [5:0]  j;
  logic [15:0] lfsr_step;
  logic        winner;

  function automatic logic [1:0] suit_of(input logic [5:0] k);
    if (k >= 6'd39)      return 2'd3;
    else if (k >= 6'd26) return 2'd2;
    else if (k >= 6'd13) return 2'd1;
    else                 return 2'd0;
  endfunction

  function automatic logic [3:0] rank_of(input logic [5:0] k);
    logic [5:0] off;
    case (suit_of(k))
      2'd0:    off = 6'd0;
      2'd1:    off = 6'd13;
      2'd2:    off = 6'd26;
      default: off = 6'd39;
    endcase
    return 4'(k - off + 6'd1);
  endfunction

  function automatic logic [3:0] value_of(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DECK_SIZE; k++) deck_q[k] <= 6'(k);
      state_q <= READY;
      ptr_q   <= 6'd0;
      left_q  <= FULL;
      i_q     <= 6'd0;
      card_q  <= 6'd0;
      lfsr_q  <= LFSR_DEFAULT;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
    end else begin
      deck_q  <= deck_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      left_q  <= left_d;
      i_q     <= i_d;
      card_q  <= card_d;
      lfsr_q  <= lfsr_d;
      last_q  <= last_d;
      win_q   <= win_d;
    end
  end

  assign j         = lfsr_q[5:0];
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  // With both requesting, the one not served last wins; otherwise the sole requester.
  assign winner    = (req == 2'b11) ? ~last_q : req[1];

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    deck_d  = deck_q;
    ptr_d   = ptr_q;
    left_d  = left_q;
    i_d     = i_q;
    card_d  = card_q;
    lfsr_d  = lfsr_q;
    last_d  = last_q;
    win_d   = win_q;
    case (state_q)
      READY: begin
        if (shuffle_start) begin
          lfsr_d  = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
          i_d     = LAST_IDX;
          state_d = SHUFFLE;
        end else if (req != 2'b00 && left_q != 6'd0) begin
          card_d  = deck_q[ptr_q];
          ptr_d   = ptr_q + 6'd1;
          left_d  = left_q - 6'd1;
          last_d  = winner;
          win_d   = winner;
          state_d = SERVE;
        end
      end
      SHUFFLE: begin
        lfsr_d = lfsr_step;
        // Draws beyond the current index are rejected and retried next cycle.
        if (j <= i_q) begin
          deck_d[i_q] = deck_q[j];
          deck_d[j]   = deck_q[i_q];
          if (i_q == 6'd1) begin
            ptr_d   = 6'd0;
            left_d  = FULL;
            state_d = READY;
          end else begin
            i_d = i_q - 6'd1;
          end
        end
      end
      SERVE:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    grant      = 2'b00;
    card_valid = 1'b0;
    card_rank  = 4'd0;
    card_value = 4'd0;
    card_suit  = 2'd0;
    if (state_q == SERVE) begin
      grant      = win_q ? 2'b10 : 2'b01;
      card_valid = 1'b1;
      card_rank  = rank_of(card_q);
      card_value = value_of(rank_of(card_q));
      card_suit  = suit_of(card_q);
    end
    busy       = (state_q == SHUFFLE);
    deck_empty = (left_q == 6'd0);
    cards_left = left_q;
  end

endmodule

// File: tb/tb_card_deck_dealer.sv
// Bench for card_deck_dealer: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a deck-level reference model.
module tb_card_deck_dealer;

  logic        clk = 1'b0;
  logic        rst;
  logic        shuffle_start;
  logic [15:0] seed;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        card_valid;
  logic [3:0]  card_value;
  logic [3:0]  card_rank;
  logic [1:0]  card_suit;
  logic        busy;
  logic        deck_empty;
  logic [5:0]  cards_left;

  card_deck_dealer dut (
    .clk(clk), .rst(rst), .shuffle_start(shuffle_start), .seed(seed), .req(req),
    .grant(grant), .card_valid(card_valid), .card_value(card_value),
    .card_rank(card_rank), .card_suit(card_suit), .busy(busy),
    .deck_empty(deck_empty), .cards_left(cards_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: deck as an array of card indices, mode 0 ready / 1 shuffling / 2 serving
  int m_deck [52];
  int m_ptr, m_left, m_last, m_mode, m_cnt, m_win, m_card, m_steps;

  function automatic int model_shuffle(input logic [15:0] s);
    logic [15:0] l;
    int i, jj, t, n;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    i = 51;
    n = 0;
    while (n < 100000) begin
      jj = int'(l[5:0]);
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      n++;
      if (jj <= i) begin
        t = m_deck[i]; m_deck[i] = m_deck[jj]; m_deck[jj] = t;
        if (i == 1) break;
        i--;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 52; k++) m_deck[k] = k;
      m_ptr = 0; m_left = 52; m_last = 1; m_mode = 0;
    end else begin
      case (m_mode)
        0: begin
          if (shuffle_start) begin
            m_cnt = model_shuffle(seed);
            m_steps = m_cnt;
            m_mode = 1;
          end else if (req != 2'b00 && m_left > 0) begin
            m_win  = (req == 2'b11) ? 1 - m_last : ((req == 2'b10) ? 1 : 0);
            m_card = m_deck[m_ptr];
            m_ptr++; m_left--;
            m_last = m_win;
            m_mode = 2;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin m_ptr = 0; m_left = 52; m_mode = 0; end
        end
        default: m_mode = 0;
      endcase
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      int r;
      chk("grant", 32'(grant), (m_mode == 2) ? ((m_win == 1) ? 32'd2 : 32'd1) : 32'd0);
      chk("card_valid", 32'(card_valid), 32'(m_mode == 2));
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("cards_left", 32'(cards_left), m_left);
      chk("deck_empty", 32'(deck_empty), 32'(m_left == 0));
      if (m_mode == 2) begin
        r = m_card % 13 + 1;
        chk("card_rank", 32'(card_rank), r);
        chk("card_value", 32'(card_value), (r > 10) ? 10 : r);
        chk("card_suit", 32'(card_suit), m_card / 13);
      end else begin
        chk("idle_fields", {22'd0, card_rank, card_value, card_suit}, 32'd0);
      end
    end
  end

  int seq_cur [52];
  int seq_a   [52];

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called just after a negedge; requests are driven mid-cycle, so the grant
  // must be visible one active edge later.
  task automatic deal_one(input int b, output logic [1:0] g, output int idx,
                          output logic [3:0] rk, output logic [3:0] vl,
                          output logic [1:0] st, output int lat);
    req[b] = 1'b1;
    g = 2'b00;
    lat = 0;
    while (g == 2'b00 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (grant != 2'b00) g = grant;
    end
    if (g == 2'b00) begin
      checks++; errors++;
      $display("FAIL deal_timeout actual=no_grant expected=grant");
    end
    rk = card_rank; vl = card_value; st = card_suit;
    idx = int'(card_suit) * 13 + int'(card_rank) - 1;
    req[b] = 1'b0;
    @(negedge clk);
  endtask

  task automatic deal_all(input int b);
    logic [1:0] g; logic [3:0] rk, vl; logic [1:0] st; int idx, lat;
    for (int n = 0; n < 52; n++) begin
      deal_one(b, g, idx, rk, vl, st, lat);
      seq_cur[n] = idx;
    end
  endtask

  task automatic shuffle_pulse(input logic [15:0] s, output int bc);
    shuffle_start = 1'b1;
    seed = s;
    @(negedge clk);
    shuffle_start = 1'b0;
    bc = 0;
    while (busy && bc < 5000) begin
      bc++;
      @(negedge clk);
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL shuffle_timeout actual=busy expected=idle");
    end
  endtask

  function automatic int perm_count();
    int seen [52];
    int ok;
    for (int k = 0; k < 52; k++) seen[k] = 0;
    for (int k = 0; k < 52; k++) if (seq_cur[k] >= 0 && seq_cur[k] < 52) seen[seq_cur[k]]++;
    ok = 0;
    for (int k = 0; k < 52; k++) if (seen[k] == 1) ok++;
    return ok;
  endfunction

  function automatic int same_count();
    int ok = 0;
    for (int k = 0; k < 52; k++) if (seq_cur[k] == seq_a[k]) ok++;
    return ok;
  endfunction

  initial begin
    logic [1:0] g, dropped;
    logic [3:0] rk, vl;
    logic [1:0] st;
    int idx, lat, bc, n;
    bit saw_busy, bad;
    logic [1:0] exp_alt [4];

    rst = 1'b1; shuffle_start = 1'b0; seed = 16'h0000; req = 2'b00;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_cards_left", 32'(cards_left), 32'd52);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_deck_empty", 32'(deck_empty), 32'd0);

    // Unshuffled deck: player receives spades-ish suit 0, ranks 1..13
    for (int k = 1; k <= 13; k++) begin
      deal_one(0, g, idx, rk, vl, st, lat);
      chk("seq_grant", 32'(g), 32'd1);
      chk("seq_rank", 32'(rk), k);
      chk("seq_value", 32'(vl), (k > 10) ? 10 : k);
      chk("seq_suit", 32'(st), 32'd0);
      chk("seq_latency", lat, 32'd1);
    end
    chk("left_after_13", 32'(cards_left), 32'd39);

    // Both requesting: round-robin alternation, player first
    do_reset();
    exp_alt[0] = 2'b01; exp_alt[1] = 2'b10; exp_alt[2] = 2'b01; exp_alt[3] = 2'b10;
    req = 2'b11;
    for (int a = 0; a < 4; a++) begin
      lat = 0;
      while (grant == 2'b00 && lat < 20) begin @(negedge clk); lat++; end
      chk("alt_grant", 32'(grant), 32'(exp_alt[a]));
      chk("alt_latency", lat, 32'd1);
      dropped = grant;
      req = req & ~dropped;
      @(negedge clk);
      req = req | dropped;
    end
    req = 2'b00;
    @(negedge clk);

    // Seeded shuffle yields a permutation, and is reproducible
    do_reset();
    shuffle_pulse(16'h1234, bc);
    chk("shuffle_len_ge51", 32'(bc >= 51), 32'd1);
    chk("shuffle_len_model", bc, m_steps);
    deal_all(0);
    chk("perm_1234", perm_count(), 32'd52);
    seq_a = seq_cur;

    // Empty deck: dealer request waits until reshuffle completes
    req = 2'b10;
    repeat (6) @(negedge clk);
    chk("empty_no_grant", 32'(grant), 32'd0);
    chk("empty_flag", 32'(deck_empty), 32'd1);
    shuffle_pulse(16'h1234, bc);
    lat = 0;
    while (grant == 2'b00 && lat < 20) begin @(negedge clk); lat++; end
    chk("refill_grant", 32'(grant), 32'd2);
    chk("refill_left", 32'(cards_left), 32'd51);
    req = 2'b00;
    @(negedge clk);

    do_reset();
    shuffle_pulse(16'h1234, bc);
    deal_all(1);
    chk("repeat_same_seq", same_count(), 32'd52);

    // Shuffle outranks a simultaneous request; seed 0 aliases to ACE1
    do_reset();
    shuffle_start = 1'b1; seed = 16'h0000; req = 2'b01;
    @(negedge clk);
    shuffle_start = 1'b0;
    chk("tie_busy", 32'(busy), 32'd1);
    chk("tie_no_grant", 32'(grant), 32'd0);
    saw_busy = 1'b0; bad = 1'b0; n = 0;
    while (grant == 2'b00 && n < 5000) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
      n++;
      if (grant != 2'b00 && busy) bad = 1'b1;
    end
    chk("tie_grant_player", 32'(grant), 32'd1);
    chk("tie_saw_busy", 32'(saw_busy), 32'd1);
    chk("tie_no_grant_busy", 32'(bad), 32'd0);
    req = 2'b00;
    @(negedge clk);

    do_reset();
    shuffle_pulse(16'h0000, bc);
    deal_all(0);
    seq_a = seq_cur;
    do_reset();
    shuffle_pulse(16'hACE1, bc);
    deal_all(0);
    chk("seed0_equals_ace1", same_count(), 32'd52);

    // Reset in the middle of a shuffle
    do_reset();
    shuffle_start = 1'b1; seed = 16'hBEEF;
    @(negedge clk);
    shuffle_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_shuf_busy", 32'(busy), 32'd0);
    chk("rst_shuf_grant", 32'(grant), 32'd0);
    chk("rst_shuf_left", 32'(cards_left), 32'd52);
    deal_one(0, g, idx, rk, vl, st, lat);
    chk("rst_shuf_rank", 32'(rk), 32'd1);
    chk("rst_shuf_suit", 32'(st), 32'd0);

    // Reset during the serve cycle
    req[0] = 1'b1;
    n = 0;
    while (grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("serve_seen", 32'(grant), 32'd1);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_serve_grant", 32'(grant), 32'd0);
    chk("rst_serve_busy", 32'(busy), 32'd0);
    chk("rst_serve_left", 32'(cards_left), 32'd52);
    deal_one(0, g, idx, rk, vl, st, lat);
    chk("rst_serve_rank", 32'(rk), 32'd1);
    chk("rst_serve_suit", 32'(st), 32'd0);

    // Randomized traffic; requesters hold until granted
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
        if (grant[b]) req[b] = 1'b0;
        else if (!req[b] && $urandom_range(0, 2) == 0) req[b] = 1'b1;
      end
      shuffle_start = ($urandom_range(0, 299) == 0);
      seed = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rst = ($urandom_range(0, 999) == 0);
    end
    req = 2'b00; shuffle_start = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
